// File: rtl/jt6295_pkg.sv
// Shared types and constants for the JT6295 ROM arbiter.
// The header fetcher has requester index 4; voices use indices 0..3.
package jt6295_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    localparam int         NV_DEF    = 4;
    localparam int         AW_DEF    = 18;
    localparam int         OKDLY_DEF = 2;
    localparam logic [2:0] HDR_IDX   = 3'd4;

endpackage

// File: rtl/jt6295_rr_pick.sv
// Combinational round-robin picker: first eligible voice after ptr, wrapping.
// NV must be a power of two so the pointer arithmetic wraps naturally.
module jt6295_rr_pick
    import jt6295_pkg::*;
#(
    parameter int NV = NV_DEF,
    parameter int PW = $clog2(NV)
) (
    input  logic [NV-1:0] elig,
    input  logic [PW-1:0] ptr,
    output logic [NV-1:0] gnt,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NV; i++) begin
            idx = ptr + PW'(i);
            if (!valid && elig[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt6295_rom_arb.sv
// Shares one ADPCM sample ROM port between the header fetcher (fixed priority)
// and four voice decoders (round-robin), each with a one-entry result register.
module jt6295_rom_arb
    import jt6295_pkg::*;
#(
    parameter int NV    = NV_DEF,
    parameter int AW    = AW_DEF,
    parameter int OKDLY = OKDLY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdr_cs,
    input  logic [AW-1:0]    hdr_addr,
    output logic [7:0]       hdr_dout,
    output logic             hdr_ok,
    input  logic [NV-1:0]    v_cs,
    input  logic [NV*AW-1:0] v_addr,
    output logic [NV*8-1:0]  v_dout,
    output logic [NV-1:0]    v_ok,
    output logic             busy,
    output logic             rom_cs,
    output logic [AW-1:0]    rom_addr,
    input  logic [7:0]       rom_data,
    input  logic             rom_ok
);

    localparam int            PW      = $clog2(NV);
    localparam int            CW      = $clog2(OKDLY + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OKDLY);

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       gnt_q, gnt_d;
    logic             rom_cs_q, rom_cs_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic             busy_q, busy_d;
    logic [7:0]       hdr_dout_q, hdr_dout_d;
    logic             hdr_ok_q, hdr_ok_d;
    logic [AW-1:0]    hdr_last_q, hdr_last_d;
    logic [NV*8-1:0]  v_dout_q, v_dout_d;
    logic [NV-1:0]    v_ok_q, v_ok_d;
    logic [NV*AW-1:0] v_last_q, v_last_d;

    logic             hdr_elig;
    logic [NV-1:0]    v_elig;
    logic [NV-1:0]    v_gnt;
    logic             v_valid;
    logic             capture;
    logic [PW-1:0]    v_idx;
    logic [AW-1:0]    v_gnt_addr;

    // A requester holding valid data for its address never competes.
    assign hdr_elig = hdr_cs & ~hdr_ok_q;
    assign v_elig   = v_cs & ~v_ok_q;
    assign capture  = (state_q == ST_WAIT) && rom_ok && (cnt_q == CNT_MAX);

    jt6295_rr_pick #(.NV(NV), .PW(PW)) u_pick (
        .elig  (v_elig),
        .ptr   (ptr_q),
        .gnt   (v_gnt),
        .valid (v_valid)
    );

    always_comb begin
        v_idx      = '0;
        v_gnt_addr = '0;
        for (int i = 0; i < NV; i++) begin
            if (v_gnt[i]) begin
                v_idx      = PW'(i);
                v_gnt_addr = v_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                rom_cs_d = 1'b0;
                if (hdr_elig) begin
                    gnt_d      = HDR_IDX;
                    rom_addr_d = hdr_addr;
                end else if (v_valid) begin
                    gnt_d      = 3'(v_idx);
                    ptr_d      = v_idx;
                    rom_addr_d = v_gnt_addr;
                end
                if (hdr_elig || v_valid) begin
                    rom_cs_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // rom_ok must stay high OKDLY edges in a row before data is trusted.
                if (!rom_ok) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (capture) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture overrides invalidation; ok is set only if the requester still wants this address.
    always_comb begin
        hdr_dout_d = hdr_dout_q;
        hdr_last_d = hdr_last_q;
        hdr_ok_d   = hdr_ok_q && (hdr_addr == hdr_last_q);
        v_dout_d   = v_dout_q;
        v_last_d   = v_last_q;
        v_ok_d     = '0;
        for (int i = 0; i < NV; i++) begin
            v_ok_d[i] = v_ok_q[i] && (v_addr[i*AW +: AW] == v_last_q[i*AW +: AW]);
        end
        if (capture) begin
            if (gnt_q == HDR_IDX) begin
                hdr_dout_d = rom_data;
                hdr_last_d = rom_addr_q;
                hdr_ok_d   = (hdr_addr == rom_addr_q);
            end
            for (int i = 0; i < NV; i++) begin
                if (gnt_q == 3'(i)) begin
                    v_dout_d[i*8 +: 8]  = rom_data;
                    v_last_d[i*AW +: AW] = rom_addr_q;
                    v_ok_d[i]            = (v_addr[i*AW +: AW] == rom_addr_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PW'(NV - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            hdr_dout_q <= '0;
            hdr_ok_q   <= 1'b0;
            hdr_last_q <= '0;
            v_dout_q   <= '0;
            v_ok_q     <= '0;
            v_last_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            hdr_dout_q <= hdr_dout_d;
            hdr_ok_q   <= hdr_ok_d;
            hdr_last_q <= hdr_last_d;
            v_dout_q   <= v_dout_d;
            v_ok_q     <= v_ok_d;
            v_last_q   <= v_last_d;
        end
    end

    assign hdr_dout = hdr_dout_q;
    assign hdr_ok   = hdr_ok_q;
    assign v_dout   = v_dout_q;
    assign v_ok     = v_ok_q;
    assign busy     = busy_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Directed bench for jt6295_rom_arb: ROM model returns addr[7:0]; a monitor
// logs grants and checks every valid result against the ROM model each cycle.
module tb_jt6295_rom_arb;

    localparam int NV    = 4;
    localparam int AW    = 18;
    localparam int OKDLY = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hdr_cs;
    logic [AW-1:0]    hdr_addr;
    logic [7:0]       hdr_dout;
    logic             hdr_ok;
    logic [NV-1:0]    v_cs;
    logic [NV*AW-1:0] v_addr;
    logic [NV*8-1:0]  v_dout;
    logic [NV-1:0]    v_ok;
    logic             busy;
    logic             rom_cs;
    logic [AW-1:0]    rom_addr;
    logic [7:0]       rom_data;
    logic             rom_ok;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    int               ok_rise[5];
    logic [AW-1:0]    exp_q[$];
    logic [AW-1:0]    grant_q[$];
    int               gcyc_q[$];
    logic             busy_p = 1'b0;
    logic [4:0]       ok_p = '0;
    logic [AW-1:0]    cur_gaddr = '0;
    logic             pat[5];

    jt6295_rom_arb #(.NV(NV), .AW(AW), .OKDLY(OKDLY)) dut (
        .clk      (clk),
        .rst      (rst),
        .hdr_cs   (hdr_cs),
        .hdr_addr (hdr_addr),
        .hdr_dout (hdr_dout),
        .hdr_ok   (hdr_ok),
        .v_cs     (v_cs),
        .v_addr   (v_addr),
        .v_dout   (v_dout),
        .v_ok     (v_ok),
        .busy     (busy),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    // Clock and ROM model
    always #5 clk = ~clk;
    assign rom_data = rom_ok ? rom_addr[7:0] : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] vaddr_of(input int i);
        return v_addr[i*AW +: AW];
    endfunction

    task automatic set_vaddr(input int i, input logic [AW-1:0] a);
        v_addr[i*AW +: AW] = a;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        grant_q.delete();
        gcyc_q.delete();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (grant_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (grant_q.size() < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_grants: got %0d grants expected %0d", grant_q.size(), n);
        end
    endtask

    task automatic wait_ok(input int i, input int budget);
        int t = 0;
        while (!({hdr_ok, v_ok}[i]) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("wait_ok%0d", i), 32'({hdr_ok, v_ok}[i]), 32'd1);
    endtask

    task automatic wait_all_voices(input int budget);
        int t = 0;
        while (v_ok != 4'hF && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("all_voices_ok", 32'(v_ok), 32'hF);
    endtask

    // Scoreboard: compare observed grant addresses against the expected queue.
    task automatic check_grants();
        check("grant_count", 32'(grant_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && grant_q.size() > 0)
            check("grant_addr", 32'(grant_q.pop_front()), 32'(exp_q.pop_front()));
        clear_logs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hdr_dout"}, 32'(hdr_dout), 32'd0);
        check({tag, "_hdr_ok"}, 32'(hdr_ok), 32'd0);
        check({tag, "_v_dout"}, v_dout, 32'd0);
        check({tag, "_v_ok"}, 32'(v_ok), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rom_cs"}, 32'(rom_cs), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    // Monitor: grant log, result-vs-ROM model, address stability while busy.
    initial begin
        for (int i = 0; i < 5; i++) ok_rise[i] = -1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && !busy_p) begin
                grant_q.push_back(rom_addr);
                gcyc_q.push_back(cyc);
                cur_gaddr = rom_addr;
            end else if (busy) begin
                check("rom_addr_stable", 32'(rom_addr), 32'(cur_gaddr));
            end
            if (busy) check("busy_rom_cs", 32'(rom_cs), 32'd1);
            if (hdr_ok) check("hdr_dout_model", 32'(hdr_dout), 32'(hdr_addr[7:0]));
            for (int i = 0; i < NV; i++) begin
                if (v_ok[i]) begin
                    logic [AW-1:0] a;
                    a = vaddr_of(i);
                    check($sformatf("v_dout%0d_model", i), 32'(v_dout[i*8 +: 8]), 32'(a[7:0]));
                end
            end
            for (int i = 0; i < 5; i++)
                if ({hdr_ok, v_ok}[i] && !ok_p[i]) ok_rise[i] = cyc;
            busy_p = busy;
            ok_p   = {hdr_ok, v_ok};
        end
    end

    initial begin
        hdr_cs   = 1'b0;
        hdr_addr = '0;
        v_cs     = '0;
        v_addr   = '0;
        rom_ok   = 1'b1;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single voice, cold read
        @(negedge clk);
        v_cs = 4'b0001;
        set_vaddr(0, 18'h00123);
        wait_grants(1, 20);
        wait_ok(0, 20);
        if (gcyc_q.size() > 0) check("cold_latency", 32'(ok_rise[0] - gcyc_q[0]), 32'd3);
        check("cold_dout", 32'(v_dout[7:0]), 32'h23);
        repeat (20) @(negedge clk);
        check("hold_no_rom_cs", 32'(rom_cs), 32'd0);
        exp_q.push_back(18'h00123);
        check_grants();

        // Round-robin from reset, two rounds
        rst = 1'b1;
        @(negedge clk);
        v_cs = 4'hF;
        set_vaddr(0, 18'h01010);
        set_vaddr(1, 18'h02021);
        set_vaddr(2, 18'h03032);
        set_vaddr(3, 18'h04043);
        clear_logs();
        @(negedge clk);
        rst = 1'b0;
        wait_grants(4, 40);
        for (int k = 0; k < 3; k++)
            if (gcyc_q.size() > k + 1) check("rr_spacing", 32'(gcyc_q[k+1] - gcyc_q[k]), 32'd4);
        exp_q = '{18'h01010, 18'h02021, 18'h03032, 18'h04043};
        check_grants();
        wait_all_voices(20);
        @(negedge clk);
        set_vaddr(0, 18'h05054);
        set_vaddr(1, 18'h06065);
        set_vaddr(2, 18'h07076);
        set_vaddr(3, 18'h08087);
        wait_grants(4, 40);
        exp_q = '{18'h05054, 18'h06065, 18'h07076, 18'h08087};
        check_grants();
        wait_all_voices(20);

        // Header priority while voice 1 waits; voice 0 joins late and goes last
        @(negedge clk);
        set_vaddr(1, 18'h00111);
        set_vaddr(2, 18'h00222);
        set_vaddr(3, 18'h00333);
        wait_grants(1, 20);
        hdr_cs   = 1'b1;
        hdr_addr = 18'h00A5A;
        set_vaddr(0, 18'h00444);
        wait_grants(5, 60);
        exp_q = '{18'h00111, 18'h00A5A, 18'h00222, 18'h00333, 18'h00444};
        check_grants();
        wait_ok(4, 20);
        check("hdr_dout", 32'(hdr_dout), 32'h5A);
        wait_all_voices(20);

        // Settling: rom_ok 1,0,1,1,1 after the grant
        @(negedge clk);
        set_vaddr(0, 18'h00777);
        wait_grants(1, 20);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            rom_ok = pat[k];
            @(negedge clk);
        end
        wait_ok(0, 20);
        if (gcyc_q.size() > 0) check("settle_latency", 32'(ok_rise[0] - gcyc_q[0]), 32'd5);
        check("settle_dout", 32'(v_dout[7:0]), 32'h77);
        exp_q.push_back(18'h00777);
        check_grants();

        // rom_ok low for 50 cycles: no timeout
        rom_ok = 1'b0;
        set_vaddr(0, 18'h00888);
        repeat (50) @(negedge clk);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_rom_cs", 32'(rom_cs), 32'd1);
        check("stall_rom_addr", 32'(rom_addr), 32'h00888);
        check("stall_no_ok", 32'(v_ok[0]), 32'd0);
        rom_ok = 1'b1;
        wait_ok(0, 20);
        check("stall_dout", 32'(v_dout[7:0]), 32'h88);
        exp_q.push_back(18'h00888);
        check_grants();

        // Address change in flight on voice 2
        @(negedge clk);
        set_vaddr(2, 18'h00100);
        wait_grants(1, 20);
        set_vaddr(2, 18'h00101);
        wait_grants(2, 30);
        if (gcyc_q.size() > 1) check("regrant_gap", 32'(gcyc_q[1] - gcyc_q[0]), 32'd4);
        wait_ok(2, 20);
        if (gcyc_q.size() > 1) check("regrant_ok_time", 32'(ok_rise[2] - gcyc_q[1]), 32'd3);
        check("regrant_dout", 32'(v_dout[23:16]), 32'h01);
        exp_q = '{18'h00100, 18'h00101};
        check_grants();

        // Reset in the middle of WAIT
        rom_ok = 1'b0;
        set_vaddr(3, 18'h00999);
        wait_grants(1, 20);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        hdr_cs = 1'b0;
        set_vaddr(0, 18'h0A0A0);
        set_vaddr(1, 18'h0B0B1);
        set_vaddr(2, 18'h0C0C2);
        set_vaddr(3, 18'h0D0D3);
        rom_ok = 1'b1;
        clear_logs();
        @(negedge clk);
        rst = 1'b0;
        wait_grants(4, 40);
        exp_q = '{18'h0A0A0, 18'h0B0B1, 18'h0C0C2, 18'h0D0D3};
        check_grants();
        wait_all_voices(20);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
